frame_reader: RTL and testbench

//  Display-side counterpart of the frame-fill path: streams a frame buffer out of DDR2 in raster order.
//  - Issues 8-pixel read bursts on the DDR2 address FIFO.
//  - Credit-checks every burst so all returned data is guaranteed buffer space.
//  - Unpacks 128-bit read beats into 24-bit pixels on a valid/ready stream feeding the video timing block.

---
 rtl/frame_reader.sv | 154 +++++++++++++++
 tb/tb_frame_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// Streams a frame from DDR2 in raster order: credit-checked 2-beat read bursts, 128-bit beats unpacked to 24-bit pixels.
// Beat written in cycle n shows as video_valid in n+1; issue stalls on af_full or missing buffer credit, pixels hold while !video_ready.
module frame_reader #(
  parameter int FIFO_DEPTH = 64,
  parameter int H_PIXELS   = 800,
  parameter int V_LINES    = 600
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [31:0]  frame_base,
  input  logic         af_full,
  output logic         af_wr_en,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  input  logic         rdf_valid,
  input  logic [127:0] rdf_dout,
  output logic         rdf_rd_en,
  output logic [23:0]  video,
  output logic         video_valid,
  input  logic         video_ready,
  output logic         video_sof
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [5:0]     frame;
  logic [9:0]     x, y;
  logic [9:0]     out_x, out_y;
  logic [AW:0]    pending, count;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [1:0]     pix_idx;
  logic [127:0]   mem [FIFO_DEPTH];
  logic [127:0]   head;
  logic [23:0]    pixel;
  logic [CW-1:0]  need;
  logic           credit_ok, issue, beat_wr, beat_pop, pix_acc;
  logic           unused_ok;

  assign unused_ok = ^{frame_base[31:28], frame_base[21:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE && enable) state_nxt = RUN;
  end

  // Every burst must have room reserved for both of its beats before it is issued.
  assign need      = CW'(count) + CW'(pending) + CW'(2);
  assign credit_ok = need <= CW'(FIFO_DEPTH);

  always_comb begin
    af_wr_en = 1'b0;
    if (state == RUN) af_wr_en = !af_full && credit_ok;
  end

  assign issue       = af_wr_en;
  assign af_cmd_din  = 3'b001;
  assign af_addr_din = {6'b0, frame, y, x[9:3], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      frame <= '0;
    end else if (state == IDLE && enable) begin
      frame <= frame_base[27:22];
    end else if (issue) begin
      if (x == 10'(H_PIXELS - 8)) begin
        x <= '0;
        if (y == 10'(V_LINES - 1)) begin
          y     <= '0;
          frame <= frame_base[27:22];
        end else begin
          y <= y + 10'd1;
        end
      end else begin
        x <= x + 10'd8;
      end
    end
  end

  // Beats with nothing outstanding belong to requests issued before a reset; drop them.
  assign rdf_rd_en = rdf_valid;
  assign beat_wr   = rdf_valid && (pending != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      case ({issue, beat_wr})
        2'b10:   pending <= pending + (AW+1)'(2);
        2'b11:   pending <= pending + (AW+1)'(1);
        2'b01:   pending <= pending - (AW+1)'(1);
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr) mem[wr_ptr] <= rdf_dout;
  end

  assign head        = mem[rd_ptr];
  assign pixel       = head[32*pix_idx +: 24];
  assign video_valid = (count != '0);
  assign video       = video_valid ? pixel : 24'd0;
  assign pix_acc     = video_valid && video_ready;
  assign beat_pop    = pix_acc && (pix_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pix_idx <= '0;
    end else begin
      if (beat_wr)  wr_ptr  <= wr_ptr + AW'(1);
      if (beat_pop) rd_ptr  <= rd_ptr + AW'(1);
      if (pix_acc)  pix_idx <= pix_idx + 2'd1;
      case ({beat_wr, beat_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Display-side raster position; sof marks pixel (0,0) of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_x <= '0;
      out_y <= '0;
    end else if (pix_acc) begin
      if (out_x == 10'(H_PIXELS - 1)) begin
        out_x <= '0;
        out_y <= (out_y == 10'(V_LINES - 1)) ? 10'd0 : out_y + 10'd1;
      end else begin
        out_x <= out_x + 10'd1;
      end
    end
  end

  assign video_sof = video_valid && (out_x == '0) && (out_y == '0);

endmodule

// File: tb/tb_frame_reader.sv
// Randomised bench for frame_reader: ideal 10-cycle DDR2 model plus raster-order reference for addresses and pixels.
module tb_frame_reader;

  localparam int DEPTH     = 64;
  localparam int HP        = 800;
  localparam int VL        = 4;
  localparam int LINE_REQ  = HP / 8;
  localparam int FRAME_REQ = LINE_REQ * VL;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [31:0]  frame_base = '0;
  logic         af_full = 1'b0;
  logic         af_wr_en;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         rdf_valid = 1'b0;
  logic [127:0] rdf_dout = '0;
  logic         rdf_rd_en;
  logic [23:0]  video;
  logic         video_valid;
  logic         video_ready = 1'b0;
  logic         video_sof;

  frame_reader #(.FIFO_DEPTH(DEPTH), .H_PIXELS(HP), .V_LINES(VL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_base(frame_base),
    .af_full(af_full), .af_wr_en(af_wr_en), .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din),
    .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .rdf_rd_en(rdf_rd_en),
    .video(video), .video_valid(video_valid), .video_ready(video_ready), .video_sof(video_sof)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [127:0] data; } beat_t;
  typedef struct { logic [23:0] pix; logic sof; } pix_t;

  beat_t       mq[$];
  pix_t        pq[$];
  logic [30:0] alog[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, issued = 0, accepted = 0, req_n = 0;
  int          ready_mode = 0, full_mode = 0;
  bit          literal = 1'b0;
  logic [5:0]  m_frame = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pv(input logic [30:0] a, input int b, input int k);
    if (literal) return 24'(k + 1);
    return 24'(int'(a[20:2]) * 8 + b * 4 + k) ^ 24'hA5C3F0;
  endfunction

  // Memory returns one beat per cycle, ten cycles after the command; also drives consumer and af_full patterns.
  initial begin : driver
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        rdf_valid = 1'b1;
        rdf_dout  = mq[0].data;
        mq.delete(0);
      end else begin
        rdf_valid = 1'b0;
        rdf_dout  = '0;
      end
      case (ready_mode)
        0:       video_ready = 1'b0;
        1:       video_ready = 1'b1;
        default: video_ready = ($urandom_range(3) != 0);
      endcase
      case (full_mode)
        0:       af_full = 1'b0;
        2:       af_full = 1'b1;
        default: af_full = ($urandom_range(9) == 0);
      endcase
    end
  end

  initial begin : monitor
    logic [30:0] ea;
    beat_t bt;
    pix_t  px;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (af_wr_en) begin
          ea = {6'b0, m_frame, 10'(req_n / LINE_REQ), 7'(req_n % LINE_REQ), 2'b00};
          chk("req_addr", 128'(af_addr_din), 128'(ea));
          chk("credit_bound", 128'(2 * issued - accepted / 4 + 2 <= DEPTH), 128'(1));
          for (int b = 0; b < 2; b++) begin
            bt.due  = cyc + 10;
            bt.data = '0;
            for (int k = 0; k < 4; k++) begin
              bt.data[32*k +: 32] = {literal ? 8'h00 : 8'($urandom), pv(af_addr_din, b, k)};
              px.pix = pv(ea, b, k);
              px.sof = (req_n == 0 && b == 0 && k == 0);
              pq.push_back(px);
            end
            mq.push_back(bt);
          end
          alog.push_back(af_addr_din);
          issued++;
          req_n++;
          if (req_n == FRAME_REQ) begin
            req_n   = 0;
            m_frame = frame_base[27:22];
          end
        end
        if (video_valid && video_ready) begin
          chk("pix_expected", 128'(pq.size() != 0), 128'(1));
          if (pq.size() != 0) begin
            px = pq.pop_front();
            chk("pix_value", 128'(video), 128'(px.pix));
            chk("pix_sof", 128'(video_sof), 128'(px.sof));
          end
          accepted++;
        end
      end
    end
  end

  initial begin : stimulus
    logic [30:0] held;
    int stale;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_af_wr_en", 128'(af_wr_en), 128'(0));
    chk("rst_cmd", 128'(af_cmd_din), 128'(3'b001));
    chk("rst_addr", 128'(af_addr_din), 128'(0));
    chk("rst_video_valid", 128'(video_valid), 128'(0));
    chk("rst_video", 128'(video), 128'(0));
    chk("rst_sof", 128'(video_sof), 128'(0));
    chk("rst_rd_en", 128'(rdf_rd_en), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Unpack with literal beats 4,3,2,1 packed in 32-bit lanes
    literal    = 1'b1;
    ready_mode = 1;
    frame_base = 32'h0040_0000;
    m_frame    = 6'd1;
    req_n      = 0;
    enable     = 1'b1;
    repeat (150) @(posedge clk);
    chk("unpack_progress", 128'(accepted >= 8), 128'(1));

    // Mid-stream reset: outputs clear, in-flight beats dropped
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    pq.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_af_wr_en", 128'(af_wr_en), 128'(0));
    chk("mid_rst_addr", 128'(af_addr_din), 128'(0));
    chk("mid_rst_video_valid", 128'(video_valid), 128'(0));
    chk("mid_rst_video", 128'(video), 128'(0));
    chk("mid_rst_sof", 128'(video_sof), 128'(0));
    chk("mid_rst_rd_en", 128'(rdf_rd_en), 128'(rdf_valid));
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    literal  = 1'b0;
    issued   = 0;
    accepted = 0;
    req_n    = 0;
    alog.delete();
    stale    = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rdf_rd_en) stale++;
      chk("no_valid_after_reset", 128'(video_valid), 128'(0));
    end
    for (int i = 0; i < 300 && mq.size() != 0; i++) @(negedge clk);
    chk("stale_drained", 128'(mq.size()), 128'(0));
    chk("stale_seen", 128'(stale > 0), 128'(1));
    chk("stale_no_valid", 128'(video_valid), 128'(0));

    // Credits: consumer stalled, exactly DEPTH/2 bursts
    ready_mode = 0;
    @(posedge clk); #1;
    frame_base = 32'h00C0_0000;
    m_frame    = 6'd3;
    req_n      = 0;
    enable     = 1'b1;
    repeat (200) @(negedge clk);
    chk("credit_requests", 128'(issued), 128'(DEPTH / 2));
    chk("credit_stall", 128'(af_wr_en), 128'(0));
    chk("credit_valid", 128'(video_valid), 128'(1));
    ready_mode = 2;
    for (int i = 0; i < 600 && issued < 40; i++) @(negedge clk);
    chk("credit_resume", 128'(issued >= 40), 128'(1));

    // af_full hold: no issue, address frozen, single issue on release
    ready_mode = 1;
    @(negedge clk);
    full_mode = 2;
    @(negedge clk);
    held = af_addr_din;
    for (int i = 0; i < 20; i++) begin
      chk("full_no_issue", 128'(af_wr_en), 128'(0));
      chk("full_addr_hold", 128'(af_addr_din), 128'(held));
      @(negedge clk);
    end
    full_mode = 0;
    @(negedge clk);
    chk("full_release_issue", 128'(af_wr_en), 128'(1));
    chk("full_release_addr", 128'(af_addr_din), 128'(held));

    // Random traffic through a frame wrap with a mid-frame frame_base change
    ready_mode = 2;
    full_mode  = 1;
    for (int i = 0; i < 20000 && issued < 200; i++) @(negedge clk);
    chk("mid_frame_reached", 128'(issued >= 200), 128'(1));
    @(posedge clk); #1;
    frame_base = 32'h0100_0000;
    for (int i = 0; i < 40000 && issued < FRAME_REQ + LINE_REQ + 5; i++) @(negedge clk);
    chk("second_frame_reached", 128'(issued >= FRAME_REQ + LINE_REQ + 5), 128'(1));
    chk("addr_first", 128'(alog[0]), 128'(31'h18_0000));
    chk("addr_line_end", 128'(alog[LINE_REQ - 1]), 128'(31'h18_018C));
    chk("addr_line1", 128'(alog[LINE_REQ]), 128'(31'h18_0200));
    chk("addr_frame_last", 128'(alog[FRAME_REQ - 1]), 128'(31'h18_0000 | ((VL - 1) << 9) | (99 << 2)));
    chk("addr_new_frame", 128'(alog[FRAME_REQ]), 128'(31'h20_0000));
    chk("addr_new_frame_line1", 128'(alog[FRAME_REQ + LINE_REQ]), 128'(31'h20_0200));

    ready_mode = 1;
    full_mode  = 0;
    repeat (50) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
